// File: rtl/snake_display_pkg.sv
// Shared types and constants for the snake score display: conversion FSM states,
// anode patterns and the digit-to-segment table.
package snake_display_pkg;

    localparam int unsigned BIN_W   = 8;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned SHIFT_W = BIN_W + BCD_W;
    localparam int unsigned CNT_W   = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] AN_DIG3 = 8'hF7;
    localparam logic [7:0] AN_HUND = 8'hFB;
    localparam logic [7:0] AN_TENS = 8'hFD;
    localparam logic [7:0] AN_ONES = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Active-low {Ca..Cg, Dp}; decimal point always off
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'b0000_0011;
            4'd1:    seg = 8'b1001_1111;
            4'd2:    seg = 8'b0010_0101;
            4'd3:    seg = 8'b0000_1101;
            4'd4:    seg = 8'b1001_1001;
            4'd5:    seg = 8'b0100_1001;
            4'd6:    seg = 8'b0100_0001;
            4'd7:    seg = 8'b0001_1111;
            4'd8:    seg = 8'b0000_0001;
            4'd9:    seg = 8'b0000_1001;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/snake_bin2bcd.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD, one bit per clock.
// Busy covers the shift and done cycles; the result and its operand update together.
module snake_bin2bcd
    import snake_display_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [BIN_W-1:0]   i_bin,
    output logic               o_busy,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd,
    output logic [BIN_W-1:0]   o_operand
);

    conv_state_t        r_state;
    conv_state_t        w_state_next;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] w_adj;
    logic [SHIFT_W-1:0] w_shifted;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_operand_lat;
    logic [BIN_W-1:0]   r_operand;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_busy;
    logic               r_done;
    logic               w_load;
    logic               w_step;
    logic               w_finish;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_finish     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Add 3 to every BCD nibble >= 5, then shift the whole register left
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[BIN_W + 4*i +: 4] >= 4'd5) begin
                w_adj[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        w_shifted = {w_adj[SHIFT_W-2:0], 1'b0};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_operand_lat <= '0;
            r_operand     <= '0;
            r_bcd         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_shift       <= {{BCD_W{1'b0}}, i_bin};
                r_cnt         <= '0;
                r_operand_lat <= i_bin;
                r_busy        <= 1'b1;
            end
            if (w_step) begin
                r_shift <= w_shifted;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_bcd     <= r_shift[SHIFT_W-1:BIN_W];
                r_operand <= r_operand_lat;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_bcd     = r_bcd;
    assign o_operand = r_operand;

endmodule

// File: rtl/snake_score_display.sv
// Snake score display: converts the snake length to BCD on change and scans four
// digits onto the seven-segment display with registered anode/cathode outputs.
module snake_score_display
    import snake_display_pkg::*;
#(
    parameter int unsigned SCAN_BITS  = 18,
    parameter int unsigned INIT_VALUE = 3
)(
    input  logic        board_clk,
    input  logic        Reset,
    input  logic [7:0]  Length,
    input  logic        Show_Init,
    output logic [7:0]  An,
    output logic [7:0]  Ssd_Cathodes,
    output logic [11:0] Bcd,
    output logic        Busy
);

    localparam int unsigned SCAN_W = SCAN_BITS + 2;

    logic [BIN_W-1:0]  w_src;
    logic [BIN_W-1:0]  w_last_val;
    logic              w_start;
    logic              w_busy;
    logic              w_done;
    logic [BCD_W-1:0]  w_bcd;

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        w_sel;
    logic [7:0]        w_an_c;
    logic [3:0]        w_digit_c;
    logic [7:0]        r_an;
    logic [7:0]        r_cath;

    assign w_src = Show_Init ? BIN_W'(INIT_VALUE) : Length;

    // Compare only while idle so a change mid-conversion is picked up afterwards
    assign w_start = !w_busy && (w_src != w_last_val);

    snake_bin2bcd u_bin2bcd (
        .i_clk     (board_clk),
        .i_rst     (Reset),
        .i_start   (w_start),
        .i_bin     (w_src),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_bcd     (w_bcd),
        .o_operand (w_last_val)
    );

    always_ff @(posedge board_clk) begin
        if (!Reset && w_done) begin
            assert (w_bcd[11:8] <= 4'd2 && w_bcd[7:4] <= 4'd9 && w_bcd[3:0] <= 4'd9);
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    assign w_sel = r_scan_cnt[SCAN_W-1 -: 2];

    always_comb begin
        w_an_c    = AN_OFF;
        w_digit_c = 4'd0;
        case (w_sel)
            2'd0: w_an_c = AN_DIG3;
            2'd1: begin
                w_an_c    = AN_HUND;
                w_digit_c = w_bcd[11:8];
            end
            2'd2: begin
                w_an_c    = AN_TENS;
                w_digit_c = w_bcd[7:4];
            end
            default: begin
                w_an_c    = AN_ONES;
                w_digit_c = w_bcd[3:0];
            end
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_an   <= AN_OFF;
            r_cath <= SEG_BLANK;
        end else begin
            r_an   <= w_an_c;
            r_cath <= seg_encode(w_digit_c);
        end
    end

    assign An           = r_an;
    assign Ssd_Cathodes = r_cath;
    assign Bcd          = w_bcd;
    assign Busy         = w_busy;

endmodule

// File: tb/tb_snake_score_display.sv
// Directed self-checking bench for snake_score_display with a short scan period.
module tb_snake_score_display;

    logic        board_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic [7:0]  Length    = 8'd0;
    logic        Show_Init = 1'b1;
    logic [7:0]  An;
    logic [7:0]  Ssd_Cathodes;
    logic [11:0] Bcd;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;

    snake_score_display #(
        .SCAN_BITS  (2),
        .INIT_VALUE (3)
    ) dut (
        .board_clk    (board_clk),
        .Reset        (Reset),
        .Length       (Length),
        .Show_Init    (Show_Init),
        .An           (An),
        .Ssd_Cathodes (Ssd_Cathodes),
        .Bcd          (Bcd),
        .Busy         (Busy)
    );

    always #5 board_clk = ~board_clk;

    task automatic step(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Show_Init = 1'b1; Length = 8'd0;
        step(3);
        n_checks++; if (An !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h want ff", An); end
        n_checks++; if (Ssd_Cathodes !== 8'hFF) begin n_fail++; $display("FAIL reset_cath: got %h want ff", Ssd_Cathodes); end
        n_checks++; if (Bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h want 000", Bcd); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        Reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            n_checks++;
            if (Busy !== 1'b1) begin n_fail++; $display("FAIL init_busy cycle %0d: got %b want 1", i, Busy); end
        end
        step(1);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_end: got %b want 0", Busy); end
        n_checks++; if (Bcd !== 12'h003) begin n_fail++; $display("FAIL init_bcd: got %h want 003", Bcd); end
    endtask

    task automatic test_conversions();
        logic [7:0]  vin  [5];
        logic [11:0] vexp [5];
        logic [11:0] prev;
        vin[0] = 8'd255; vexp[0] = 12'h255;
        vin[1] = 8'd0;   vexp[1] = 12'h000;
        vin[2] = 8'd99;  vexp[2] = 12'h099;
        vin[3] = 8'd128; vexp[3] = 12'h128;
        vin[4] = 8'd7;   vexp[4] = 12'h007;
        prev = 12'h003;
        Show_Init = 1'b0;
        for (int v = 0; v < 5; v++) begin
            Length = vin[v];
            step(9);
            n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL conv_busy len=%0d: got %b want 1", vin[v], Busy); end
            n_checks++; if (Bcd !== prev) begin n_fail++; $display("FAIL conv_early len=%0d: got %h want %h", vin[v], Bcd, prev); end
            step(1);
            n_checks++; if (Bcd !== vexp[v]) begin n_fail++; $display("FAIL conv_bcd len=%0d: got %h want %h", vin[v], Bcd, vexp[v]); end
            n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL conv_idle len=%0d: got %b want 0", vin[v], Busy); end
            prev = vexp[v];
        end
    endtask

    task automatic test_back_to_back();
        Length = 8'd100;
        step(3);
        Length = 8'd42;
        step(7);
        n_checks++; if (Bcd !== 12'h100) begin n_fail++; $display("FAIL b2b_first: got %h want 100", Bcd); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b want 0", Busy); end
        step(1);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b want 1", Busy); end
        step(9);
        n_checks++; if (Bcd !== 12'h042) begin n_fail++; $display("FAIL b2b_second: got %h want 042", Bcd); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", Busy); end
    endtask

    task automatic test_scan();
        logic [7:0] an_exp   [4];
        logic [7:0] cath_exp [4];
        logic [7:0] prev_an;
        bit         found;
        an_exp[0] = 8'hF7; cath_exp[0] = 8'b0000_0011;
        an_exp[1] = 8'hFB; cath_exp[1] = 8'b0010_0101;
        an_exp[2] = 8'hFD; cath_exp[2] = 8'b0100_1001;
        an_exp[3] = 8'hFE; cath_exp[3] = 8'b0100_1001;
        Length = 8'd255;
        step(12);
        n_checks++; if (Bcd !== 12'h255) begin n_fail++; $display("FAIL scan_bcd: got %h want 255", Bcd); end
        found   = 1'b0;
        prev_an = An;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (An === 8'hF7 && prev_an !== 8'hF7) found = 1'b1;
            else prev_an = An;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL scan_sync: got no F7 onset want onset within 40 cycles"); end
        if (found) begin
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (An !== an_exp[j/4]) begin n_fail++; $display("FAIL scan_an cycle %0d: got %h want %h", j, An, an_exp[j/4]); end
                n_checks++;
                if (Ssd_Cathodes !== cath_exp[j/4]) begin n_fail++; $display("FAIL scan_cath cycle %0d: got %b want %b", j, Ssd_Cathodes, cath_exp[j/4]); end
                step(1);
            end
        end
    endtask

    task automatic test_reset_mid();
        Length = 8'd200;
        step(4);
        #2 Reset = 1'b1;
        #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", Busy); end
        n_checks++; if (Bcd !== 12'h000) begin n_fail++; $display("FAIL mid_rst_bcd: got %h want 000", Bcd); end
        n_checks++; if (An !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_an: got %h want ff", An); end
        n_checks++; if (Ssd_Cathodes !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_cath: got %h want ff", Ssd_Cathodes); end
        @(negedge board_clk);
        Reset = 1'b0;
        step(9);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL mid_redo_busy: got %b want 1", Busy); end
        step(1);
        n_checks++; if (Bcd !== 12'h200) begin n_fail++; $display("FAIL mid_redo_bcd: got %h want 200", Bcd); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mid_redo_end: got %b want 0", Busy); end
    endtask

    task automatic test_hold();
        int busy_cycles;
        busy_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (Busy !== 1'b0) busy_cycles++;
        end
        n_checks++; if (busy_cycles != 0) begin n_fail++; $display("FAIL hold_busy: got %0d busy cycles want 0", busy_cycles); end
        n_checks++; if (Bcd !== 12'h200) begin n_fail++; $display("FAIL hold_bcd: got %h want 200", Bcd); end
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_back_to_back();
        test_scan();
        test_reset_mid();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
